// File: rtl/rx_cmd_decoder.sv
// -----------------------------------------------------------------------------
// rx_cmd_decoder
//
// Receive-side command decoder. Consumes bytes from the UART receiver, builds
// multi-byte command frames and issues single-cycle register-file and ALU
// strobes. An inter-byte timeout returns a stalled frame to IDLE.
//
// Ports:
//   CLK           clock, all logic on the rising edge
//   RST           synchronous active-low reset
//   rx_p_data     received byte
//   rx_d_valid    byte valid level from the UART (may be stretched)
//   rx_frame_err  parity/stop error, qualified by rx_d_valid
//   rf_wr_en      register-file write strobe (1 cycle)
//   rf_rd_en      register-file read strobe (1 cycle)
//   rf_addr       register-file address, held between strobes
//   rf_wr_data    register-file write data, held between strobes
//   alu_en        ALU start strobe (1 cycle)
//   alu_fun       ALU function code, held between strobes
//   cmd_err       error pulse: bad opcode/address, frame error, timeout
//   busy          a frame is partially received
// -----------------------------------------------------------------------------
module rx_cmd_decoder #(
    parameter int ADDR_W  = 4,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_p_data,
    input  logic              rx_d_valid,
    input  logic              rx_frame_err,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    output logic              alu_en,
    output logic [3:0]        alu_fun,
    output logic              cmd_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN
    } state_t;

    // First address value that does not fit in the register file.
    localparam logic [8:0] ADDR_LIM = 9'(1 << ADDR_W);

    state_t            state, state_nxt;
    logic              valid_q;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;

    logic              rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, cmd_err_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic [7:0]        rf_wr_data_nxt;
    logic [3:0]        alu_fun_nxt;

    logic accept;
    logic addr_bad;

    // One accept per UART byte, however long rx_d_valid stays high.
    assign accept   = rx_d_valid & ~valid_q;
    assign addr_bad = ({1'b0, rx_p_data} >= ADDR_LIM);
    assign busy     = (state != S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt      = state;
        to_cnt_nxt     = to_cnt;
        wr_addr_nxt    = wr_addr;
        rf_wr_en_nxt   = 1'b0;
        rf_rd_en_nxt   = 1'b0;
        alu_en_nxt     = 1'b0;
        cmd_err_nxt    = 1'b0;
        rf_addr_nxt    = rf_addr;
        rf_wr_data_nxt = rf_wr_data;
        alu_fun_nxt    = alu_fun;

        if (accept) begin
            // An accept always restarts the inter-byte window, even in the
            // cycle the timeout would otherwise fire.
            to_cnt_nxt = '0;
            if (rx_frame_err) begin
                cmd_err_nxt = 1'b1;
                state_nxt   = S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        case (rx_p_data)
                            8'hAA:   state_nxt = S_WR_ADDR;
                            8'hBB:   state_nxt = S_RD_ADDR;
                            8'hCC:   state_nxt = S_ALU_A;
                            8'hDD:   state_nxt = S_ALU_FUN;
                            default: cmd_err_nxt = 1'b1;
                        endcase
                    end
                    S_WR_ADDR: begin
                        if (addr_bad) begin
                            cmd_err_nxt = 1'b1;
                            state_nxt   = S_IDLE;
                        end else begin
                            wr_addr_nxt = rx_p_data[ADDR_W-1:0];
                            state_nxt   = S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        rf_wr_en_nxt   = 1'b1;
                        rf_addr_nxt    = wr_addr;
                        rf_wr_data_nxt = rx_p_data;
                        state_nxt      = S_IDLE;
                    end
                    S_RD_ADDR: begin
                        if (addr_bad) begin
                            cmd_err_nxt = 1'b1;
                        end else begin
                            rf_rd_en_nxt = 1'b1;
                            rf_addr_nxt  = rx_p_data[ADDR_W-1:0];
                        end
                        state_nxt = S_IDLE;
                    end
                    S_ALU_A: begin
                        rf_wr_en_nxt   = 1'b1;
                        rf_addr_nxt    = '0;
                        rf_wr_data_nxt = rx_p_data;
                        state_nxt      = S_ALU_B;
                    end
                    S_ALU_B: begin
                        rf_wr_en_nxt   = 1'b1;
                        rf_addr_nxt    = ADDR_W'(1);
                        rf_wr_data_nxt = rx_p_data;
                        state_nxt      = S_ALU_FUN;
                    end
                    S_ALU_FUN: begin
                        alu_en_nxt  = 1'b1;
                        alu_fun_nxt = rx_p_data[3:0];
                        state_nxt   = S_IDLE;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end else if (state == S_IDLE) begin
            to_cnt_nxt = '0;
        end else if (to_cnt == TO_W'(TIMEOUT)) begin
            cmd_err_nxt = 1'b1;
            state_nxt   = S_IDLE;
            to_cnt_nxt  = '0;
        end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!RST) begin
            state      <= S_IDLE;
            valid_q    <= 1'b0;
            to_cnt     <= '0;
            wr_addr    <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            cmd_err    <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_fun    <= '0;
        end else begin
            state      <= state_nxt;
            valid_q    <= rx_d_valid;
            to_cnt     <= to_cnt_nxt;
            wr_addr    <= wr_addr_nxt;
            rf_wr_en   <= rf_wr_en_nxt;
            rf_rd_en   <= rf_rd_en_nxt;
            alu_en     <= alu_en_nxt;
            cmd_err    <= cmd_err_nxt;
            rf_addr    <= rf_addr_nxt;
            rf_wr_data <= rf_wr_data_nxt;
            alu_fun    <= alu_fun_nxt;
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_rx_cmd_decoder
//
// Scoreboard bench for rx_cmd_decoder. A frame-level reference model turns
// each received byte into the expected strobe; a negedge monitor pops and
// compares whenever the DUT pulses a strobe, and checks the held outputs.
// -----------------------------------------------------------------------------
module tb_rx_cmd_decoder;

    localparam int ADDR_W  = 4;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 8;

    typedef enum logic [1:0] {EV_WR, EV_RD, EV_ALU, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [3:0]        fun;
    } ev_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [7:0]        rx_p_data = 8'h00;
    logic              rx_d_valid = 1'b0;
    logic              rx_frame_err = 1'b0;
    logic              rf_wr_en, rf_rd_en, alu_en, cmd_err, busy;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wr_data;
    logic [3:0]        alu_fun;

    rx_cmd_decoder #(.ADDR_W(ADDR_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .rx_p_data   (rx_p_data),
        .rx_d_valid  (rx_d_valid),
        .rx_frame_err(rx_frame_err),
        .rf_wr_en    (rf_wr_en),
        .rf_rd_en    (rf_rd_en),
        .rf_addr     (rf_addr),
        .rf_wr_data  (rf_wr_data),
        .alu_en      (alu_en),
        .alu_fun     (alu_fun),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [7:0]        frame[$];
    ev_t               exp_q[$];
    logic              m_prev = 1'b0;
    int                m_gap  = 0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [7:0]        h_data = '0;
    logic [3:0]        h_fun  = '0;
    logic              mon_en = 1'b0;

    task automatic push_ev(input ev_kind_t k, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d, input logic [3:0] f);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.fun = f;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic err);
        int n;
        if (err) begin
            push_ev(EV_ERR, '0, '0, '0);
            frame.delete();
            return;
        end
        frame.push_back(b);
        n = frame.size();
        case (frame[0])
            8'hAA: begin
                if (n == 2 && int'(b) >= 2 ** ADDR_W) begin
                    push_ev(EV_ERR, '0, '0, '0);
                    frame.delete();
                end else if (n == 3) begin
                    push_ev(EV_WR, frame[1][ADDR_W-1:0], b, '0);
                    frame.delete();
                end
            end
            8'hBB: begin
                if (n == 2) begin
                    if (int'(b) >= 2 ** ADDR_W) push_ev(EV_ERR, '0, '0, '0);
                    else push_ev(EV_RD, b[ADDR_W-1:0], '0, '0);
                    frame.delete();
                end
            end
            8'hCC: begin
                if (n == 2) push_ev(EV_WR, ADDR_W'(0), b, '0);
                else if (n == 3) push_ev(EV_WR, ADDR_W'(1), b, '0);
                else if (n == 4) begin
                    push_ev(EV_ALU, '0, '0, b[3:0]);
                    frame.delete();
                end
            end
            8'hDD: begin
                if (n == 2) begin
                    push_ev(EV_ALU, '0, '0, b[3:0]);
                    frame.delete();
                end
            end
            default: begin
                push_ev(EV_ERR, '0, '0, '0);
                frame.delete();
            end
        endcase
    endtask

    // One clock of the model, fed with the inputs the DUT sampled at this edge.
    task automatic model_step(input logic rst_v, input logic v, input logic [7:0] d, input logic e);
        logic acc;
        if (!rst_v) begin
            frame.delete();
            exp_q.delete();
            m_prev = 1'b0;
            m_gap  = 0;
            h_addr = '0;
            h_data = '0;
            h_fun  = '0;
            return;
        end
        acc    = v && !m_prev;
        m_prev = v;
        if (acc) begin
            m_gap = 0;
            model_byte(d, e);
        end else if (frame.size() != 0) begin
            if (m_gap == TIMEOUT) begin
                push_ev(EV_ERR, '0, '0, '0);
                frame.delete();
                m_gap = 0;
            end else begin
                m_gap++;
            end
        end else begin
            m_gap = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic rst_v, input logic v, input logic [7:0] d, input logic e);
        RST          = rst_v;
        rx_d_valid   = v;
        rx_p_data    = d;
        rx_frame_err = e;
        @(posedge CLK);
        model_step(rst_v, v, d, e);
        #1;
        if (mon_en) check("busy", 32'(busy), 32'(frame.size() != 0));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err, input int width, input int gap);
        for (int i = 0; i < width; i++) drive_cycle(1'b1, 1'b1, b, err);
        for (int i = 0; i < gap; i++) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b0, 1, 1);
    endtask

    // ---------------- monitor ----------------
    function automatic logic [3:0] kind_vec(input ev_kind_t k);
        case (k)
            EV_WR:   return 4'b1000;
            EV_RD:   return 4'b0100;
            EV_ALU:  return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    initial begin
        ev_t        e;
        logic [3:0] act_v;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                act_v = {rf_wr_en, rf_rd_en, alu_en, cmd_err};
                if (act_v != 4'b0000 || exp_q.size() != 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 32'(act_v), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_kind", 32'(act_v), 32'(kind_vec(e.kind)));
                        case (e.kind)
                            EV_WR:  begin h_addr = e.addr; h_data = e.data; end
                            EV_RD:  h_addr = e.addr;
                            EV_ALU: h_fun = e.fun;
                            default: ;
                        endcase
                    end
                end
                check("addr_data_fun", 32'({rf_addr, rf_wr_data, alu_fun}),
                      32'({h_addr, h_data, h_fun}));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_outputs",
              32'({rf_wr_en, rf_rd_en, alu_en, cmd_err, busy, rf_addr, rf_wr_data, alu_fun}), 32'h0);
        mon_en = 1'b1;

        // write, read, address limit
        send(8'hAA); send(8'h05); send(8'h3C);
        send(8'hBB); send(8'h0F);
        send(8'hBB); send(8'h10);
        // ALU frames
        send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
        send(8'hDD); send(8'hF7);
        // bad opcode, frame error mid-frame, recovery
        send(8'h55);
        send(8'hAA); send(8'h03); send_byte(8'h3C, 1'b1, 1, 1);
        send(8'hBB); send(8'h02);
        // frame error on a valid opcode
        send_byte(8'hDD, 1'b1, 1, 1); send(8'h02);
        // timeout, then a byte landing exactly in the timeout cycle
        send_byte(8'hAA, 1'b0, 1, TIMEOUT + 4);
        send_byte(8'hAA, 1'b0, 1, TIMEOUT); send_byte(8'h05, 1'b0, 1, TIMEOUT); send(8'h3C);
        send_byte(8'hAA, 1'b0, 1, TIMEOUT + 1); send(8'h05);
        // stretched valid
        send_byte(8'hBB, 1'b0, 5, 1); send_byte(8'h07, 1'b0, 5, 1);
        send_byte(8'hCC, 1'b0, 5, 2); send_byte(8'h9A, 1'b0, 5, 1);
        send_byte(8'hBC, 1'b0, 5, 1); send_byte(8'h3E, 1'b0, 5, 1);
        // reset mid-frame, released with valid already high
        send(8'hCC); send(8'h12);
        drive_cycle(1'b0, 1'b1, 8'hDD, 1'b0);
        drive_cycle(1'b1, 1'b1, 8'hDD, 1'b0);
        drive_cycle(1'b1, 0, 8'h00, 1'b0);
        send(8'h02);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                drive_cycle(1'b0, 1'($urandom), 8'($urandom), 1'b0);
            end else begin
                if (frame.size() == 0) begin
                    case ($urandom_range(0, 4))
                        0: b = 8'hAA;
                        1: b = 8'hBB;
                        2: b = 8'hCC;
                        3: b = 8'hDD;
                        default: b = 8'($urandom);
                    endcase
                end else if ($urandom_range(0, 3) == 0) begin
                    b = 8'($urandom);
                end else begin
                    b = 8'($urandom_range(0, 15));
                end
                send_byte(b, ($urandom_range(0, 19) == 0),
                          $urandom_range(1, 4),
                          ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                                      : $urandom_range(1, 3));
            end
        end

        for (int i = 0; i < TIMEOUT + 4; i++) drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
